gold_code_gen: RTL and testbench
================================

// Module: gold_code_gen
// PURPOSE
//  Downstream consumer of the shift-index generator. Accepts one code shift per AXI-stream beat,
//  builds a Gold-family code of N chips by XOR-ing two m-sequences (LFSR B pre-advanced by shift),
//  and streams the chips one per beat on a master AXI-stream, framed with tuser (first) / tlast (last).
// PARAMETERS
//  N       63          code length in chips; equals 2**LENGTH-1
//  LENGTH  $clog2(N)   LFSR degree and width of shift index / counters
//  TAPS_A  6'b000011   feedback mask of LFSR A (x^6+x+1)
//  TAPS_B  6'b100111   feedback mask of LFSR B (x^6+x^5+x^2+x+1)
//  SEED_A  '1          LFSR A load value per code (must be nonzero)
//  SEED_B  '1          LFSR B load value per code (must be nonzero)
// PORTS
//  clkin     in   1       clock
//  rstn      in   1       reset, synchronous, active-low
//  s_axis    slave  if    shift in: tdata[LENGTH-1:0]=shift, tvalid, tready; tuser ignored
//  m_axis    master if    chips out: tdata[0]=chip, upper bits 0; tvalid, tready, tuser, tlast
//  busy      out  1       high from shift accept through last chip handshake
//  shift_err out  1       one-cycle pulse when a shift >= N is accepted and dropped
// BEHAVIOUR
//  LFSR step (both): fb=^(s & TAPS); s <= {fb, s[LENGTH-1:1]}; LFSR output bit = s[0].
//  Chip = a[0] ^ b[0]. Codes are produced in order of shift acceptance.
//  States: IDLE, ADVANCE, EMIT.
//  Reset: state=IDLE; s_axis.tready=0, m_axis.tvalid=0, tuser=0, tlast=0, busy=0, shift_err=0;
//    a=SEED_A, b=SEED_B, counters=0. tready rises the cycle after rstn deasserts.
//  IDLE: s_axis.tready=1 (registered). On s_axis handshake (tvalid&&tready):
//    - shift >= N: stay IDLE, shift_err=1 next cycle, no output.
//    - shift == 0: a<=SEED_A, b<=SEED_B, chip_cnt<=0, tready<=0, busy<=1, -> EMIT.
//    - else: same loads, adv_cnt<=shift, tready<=0, busy<=1, -> ADVANCE.
//  ADVANCE: step B only, adv_cnt-1 per cycle; after exactly shift steps -> EMIT.
//    Latency accept -> first m_axis.tvalid: 1 cycle (shift 0), shift+1 cycles otherwise.
//  EMIT: m_axis.tvalid=1, tdata[0]=chip, tuser=(chip_cnt==0), tlast=(chip_cnt==N-1).
//    tdata/tuser/tlast held stable while tvalid && !tready; LFSRs do not step on stall.
//    On m_axis handshake: step A and B, chip_cnt+1. Handshake with chip_cnt==N-1:
//    tvalid<=0, busy<=0, tready<=1, -> IDLE (next shift accepted earliest one cycle later).
//  Exactly N handshakes per accepted valid shift; never a partial frame except via reset.
//  s_axis.tready is 0 in ADVANCE/EMIT; upstream tvalid held there is accepted on return to IDLE.
//  Counters: chip_cnt and adv_cnt are LENGTH bits; chip_cnt never wraps (max N-1).
//  Reset mid-ADVANCE/EMIT: next edge returns to reset values; frame abandoned, no tlast emitted.
//  Shift semantics: output code(k)[i] = A[i] ^ B[i+k], with A,B m-sequences from the seeds.
// TESTING
//  1 shift=0, tready=1 always -> 63 beats, first tdata[0]=0 (1^1), tuser on beat 0 only, tlast on beat 62,
//    sequence matches golden model; first tvalid 1 cycle after accept; next tready 1 cycle after tlast.
//  2 shift=10 -> first tvalid 11 cycles after accept; all 63 chips equal A[i]^B[i+10] (model, mod 63).
//  3 shifts 0,1,2 back-to-back from upstream -> three 63-chip frames in order, tready low during each.
//  4 random m_axis.tready (~50%) with shift=5 -> data/tuser/tlast stable during stalls, same 63 chips
//    as no-stall run.
//  5 shift=63 -> shift_err pulses 1 cycle, no m_axis.tvalid, busy stays 0, next shift=1 processed normally.
//  6 rstn low at chip 30 of shift=3 frame -> tvalid=0/busy=0 next cycle; new shift=3 frame restarts at chip 0.

Source files
------------

// File: rtl/gold_code_gen.sv
// Gold-code chip streamer: takes one code shift per input beat and emits the N-chip Gold code
// A[i] ^ B[i+shift] on an AXI-stream master, framed with tuser on the first chip and tlast on the last.
module gold_code_gen #(
    parameter int                N       = 63,
    parameter int                LENGTH  = $clog2(N),
    parameter logic [LENGTH-1:0] TAPS_A  = 6'b000011,
    parameter logic [LENGTH-1:0] TAPS_B  = 6'b100111,
    parameter logic [LENGTH-1:0] SEED_A  = '1,
    parameter logic [LENGTH-1:0] SEED_B  = '1,
    parameter int                TDATA_W = 8
) (
    input  logic                 clkin,
    input  logic                 rstn,
    input  logic [LENGTH-1:0]    s_axis_tdata_i,
    input  logic                 s_axis_tvalid_i,
    output logic                 s_axis_tready_o,
    output logic [TDATA_W-1:0]   m_axis_tdata_o,
    output logic                 m_axis_tvalid_o,
    input  logic                 m_axis_tready_i,
    output logic                 m_axis_tuser_o,
    output logic                 m_axis_tlast_o,
    output logic                 busy_o,
    output logic                 shift_err_o
);

    typedef enum logic [1:0] {IDLE, ADVANCE, EMIT} state_t;

    localparam logic [LENGTH-1:0] LAST_CHIP = LENGTH'(N - 1);
    localparam logic [LENGTH-1:0] ONE       = LENGTH'(1);
    localparam logic [LENGTH:0]   N_EXT     = (LENGTH + 1)'(N);

    function automatic logic [LENGTH-1:0] lfsr_step(input logic [LENGTH-1:0] s,
                                                     input logic [LENGTH-1:0] taps);
        return {^(s & taps), s[LENGTH-1:1]};
    endfunction

    state_t            state_q, state_d;
    logic [LENGTH-1:0] a_q, a_d;
    logic [LENGTH-1:0] b_q, b_d;
    logic [LENGTH-1:0] adv_cnt_q, adv_cnt_d;
    logic [LENGTH-1:0] chip_cnt_q, chip_cnt_d;
    logic              s_tready_q, s_tready_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic              busy_q, busy_d;
    logic              shift_err_q, shift_err_d;

    logic s_hs;
    logic m_hs;
    logic shift_oor;

    assign s_hs      = s_axis_tvalid_i && s_tready_q;
    assign m_hs      = m_tvalid_q && m_axis_tready_i;
    assign shift_oor = {1'b0, s_axis_tdata_i} >= N_EXT;

    always_ff @(posedge clkin) begin
        if (!rstn) begin
            state_q     <= IDLE;
            a_q         <= SEED_A;
            b_q         <= SEED_B;
            adv_cnt_q   <= '0;
            chip_cnt_q  <= '0;
            s_tready_q  <= 1'b0;
            m_tvalid_q  <= 1'b0;
            busy_q      <= 1'b0;
            shift_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            adv_cnt_q   <= adv_cnt_d;
            chip_cnt_q  <= chip_cnt_d;
            s_tready_q  <= s_tready_d;
            m_tvalid_q  <= m_tvalid_d;
            busy_q      <= busy_d;
            shift_err_q <= shift_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        adv_cnt_d   = adv_cnt_q;
        chip_cnt_d  = chip_cnt_q;
        s_tready_d  = s_tready_q;
        m_tvalid_d  = m_tvalid_q;
        busy_d      = busy_q;
        shift_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                s_tready_d = 1'b1;
                if (s_hs) begin
                    if (shift_oor) begin
                        shift_err_d = 1'b1;
                    end else begin
                        a_d        = SEED_A;
                        b_d        = SEED_B;
                        chip_cnt_d = '0;
                        s_tready_d = 1'b0;
                        busy_d     = 1'b1;
                        if (s_axis_tdata_i == '0) begin
                            m_tvalid_d = 1'b1;
                            state_d    = EMIT;
                        end else begin
                            adv_cnt_d = s_axis_tdata_i;
                            state_d   = ADVANCE;
                        end
                    end
                end
            end
            ADVANCE: begin
                // Valid is raised on the same edge as the final B step so the
                // first chip appears exactly shift+1 cycles after acceptance.
                b_d       = lfsr_step(b_q, TAPS_B);
                adv_cnt_d = adv_cnt_q - ONE;
                if (adv_cnt_q == ONE) begin
                    m_tvalid_d = 1'b1;
                    state_d    = EMIT;
                end
            end
            EMIT: begin
                if (m_hs) begin
                    a_d = lfsr_step(a_q, TAPS_A);
                    b_d = lfsr_step(b_q, TAPS_B);
                    if (chip_cnt_q == LAST_CHIP) begin
                        m_tvalid_d = 1'b0;
                        busy_d     = 1'b0;
                        s_tready_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        chip_cnt_d = chip_cnt_q + ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Beat fields derive only from registers, so they stay frozen while the sink stalls.
    assign s_axis_tready_o = s_tready_q;
    assign m_axis_tvalid_o = m_tvalid_q;
    assign m_axis_tdata_o  = {{(TDATA_W - 1){1'b0}}, m_tvalid_q & (a_q[0] ^ b_q[0])};
    assign m_axis_tuser_o  = m_tvalid_q && (chip_cnt_q == '0);
    assign m_axis_tlast_o  = m_tvalid_q && (chip_cnt_q == LAST_CHIP);
    assign busy_o          = busy_q;
    assign shift_err_o     = shift_err_q;

endmodule

// File: tb/tb_gold_code_gen.sv
// Bench for gold_code_gen: directed frames plus random shifts and sink stalls, checked against
// m-sequences built from the linear recurrence of each LFSR polynomial.
module tb_gold_code_gen;

    localparam int N   = 63;
    localparam int LEN = 6;
    localparam logic [LEN-1:0] TAPS_A = 6'b000011;
    localparam logic [LEN-1:0] TAPS_B = 6'b100111;
    localparam logic [LEN-1:0] SEED_A = 6'b111111;
    localparam logic [LEN-1:0] SEED_B = 6'b111111;
    localparam int SEQ_LEN = 256;

    logic           clkin = 1'b0;
    logic           rstn;
    logic [LEN-1:0] s_tdata;
    logic           s_tvalid;
    logic           s_tready;
    logic [7:0]     m_tdata;
    logic           m_tvalid;
    logic           m_tready;
    logic           m_tuser;
    logic           m_tlast;
    logic           busy;
    logic           shift_err;

    int checks = 0;
    int errors = 0;
    bit seq_a [SEQ_LEN];
    bit seq_b [SEQ_LEN];

    always #5 clkin = ~clkin;

    gold_code_gen dut (
        .clkin           (clkin),
        .rstn            (rstn),
        .s_axis_tdata_i  (s_tdata),
        .s_axis_tvalid_i (s_tvalid),
        .s_axis_tready_o (s_tready),
        .m_axis_tdata_o  (m_tdata),
        .m_axis_tvalid_o (m_tvalid),
        .m_axis_tready_i (m_tready),
        .m_axis_tuser_o  (m_tuser),
        .m_axis_tlast_o  (m_tlast),
        .busy_o          (busy),
        .shift_err_o     (shift_err)
    );

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sequence x with x[0..L-1] = seed bits and x[n+L] = XOR of taps[j]*x[n+j].
    task automatic build_sequences();
        for (int i = 0; i < LEN; i++) begin
            seq_a[i] = SEED_A[i];
            seq_b[i] = SEED_B[i];
        end
        for (int n = 0; n + LEN < SEQ_LEN; n++) begin
            bit fa = 1'b0;
            bit fb = 1'b0;
            for (int j = 0; j < LEN; j++) begin
                fa ^= TAPS_A[j] & seq_a[n + j];
                fb ^= TAPS_B[j] & seq_b[n + j];
            end
            seq_a[n + LEN] = fa;
            seq_b[n + LEN] = fb;
        end
    endtask

    // Offer shift k, then collect up to stop_after chips. hold_next >= 0 keeps s_tvalid
    // asserted with that shift during the frame, as an eager upstream would.
    task automatic run_frame(input int k, input bit rnd, input int stop_after, input int hold_next);
        int       cycles;
        int       idx;
        bit       seen;
        bit       rdy;
        bit       prev_stall;
        logic [7:0] pd;
        logic     pu;
        logic     pl;
        seen       = 1'b0;
        prev_stall = 1'b0;
        idx        = 0;
        pd         = '0;
        pu         = 1'b0;
        pl         = 1'b0;
        s_tvalid   = 1'b1;
        s_tdata    = LEN'(k);
        check("accept_tready", 32'(s_tready), 32'd1);
        tick();
        if (hold_next >= 0) s_tdata = LEN'(hold_next);
        else s_tvalid = 1'b0;
        cycles = 1;
        while (idx < stop_after && cycles < 2000) begin
            if (m_tvalid && !seen) begin
                seen = 1'b1;
                check("first_valid_latency", 32'(cycles), (k == 0) ? 32'd1 : 32'(k + 1));
            end
            if (prev_stall) begin
                check("stall_valid", 32'(m_tvalid), 32'd1);
                check("stall_tdata", 32'(m_tdata), 32'(pd));
                check("stall_tuser", 32'(m_tuser), 32'(pu));
                check("stall_tlast", 32'(m_tlast), 32'(pl));
            end
            rdy      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_tready = rdy;
            if (m_tvalid && rdy) begin
                check("chip", 32'(m_tdata), 32'(seq_a[idx] ^ seq_b[idx + k]));
                check("tuser", 32'(m_tuser), 32'(idx == 0));
                check("tlast", 32'(m_tlast), 32'(idx == N - 1));
                check("busy_in_frame", 32'(busy), 32'd1);
                check("s_tready_in_frame", 32'(s_tready), 32'd0);
                idx++;
            end
            prev_stall = m_tvalid && !rdy;
            pd = m_tdata;
            pu = m_tuser;
            pl = m_tlast;
            tick();
            cycles++;
        end
        m_tready = 1'b1;
        check("first_valid_seen", 32'(seen), 32'd1);
        check("frame_beats", 32'(idx), 32'(stop_after));
        if (stop_after == N) begin
            check("post_frame_tvalid", 32'(m_tvalid), 32'd0);
            check("post_frame_busy", 32'(busy), 32'd0);
            check("post_frame_s_tready", 32'(s_tready), 32'd1);
        end
        $display("frame shift=%0d random_ready=%0d beats=%0d cycles=%0d", k, rnd, idx, cycles);
    endtask

    initial begin
        int r;
        build_sequences();
        rstn     = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        repeat (3) tick();
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tdata", 32'(m_tdata), 32'd0);
        check("rst_tuser", 32'(m_tuser), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_shift_err", 32'(shift_err), 32'd0);
        rstn     = 1'b1;
        m_tready = 1'b1;
        tick();
        check("tready_after_reset", 32'(s_tready), 32'd1);

        // Plain frames, then three shifts offered back to back.
        run_frame(0, 1'b0, N, -1);
        run_frame(10, 1'b0, N, -1);
        run_frame(0, 1'b0, N, 1);
        run_frame(1, 1'b0, N, 2);
        run_frame(2, 1'b0, N, -1);

        // Sink stalls roughly half the time.
        run_frame(5, 1'b1, N, -1);

        // Out-of-range shift is dropped with a one-cycle error pulse.
        s_tvalid = 1'b1;
        s_tdata  = 6'd63;
        check("oor_tready", 32'(s_tready), 32'd1);
        tick();
        s_tvalid = 1'b0;
        check("oor_shift_err", 32'(shift_err), 32'd1);
        check("oor_tvalid", 32'(m_tvalid), 32'd0);
        check("oor_busy", 32'(busy), 32'd0);
        tick();
        check("oor_shift_err_clear", 32'(shift_err), 32'd0);
        check("oor_tvalid_after", 32'(m_tvalid), 32'd0);
        check("oor_busy_after", 32'(busy), 32'd0);
        check("oor_tready_after", 32'(s_tready), 32'd1);
        $display("shift=63 rejected");
        run_frame(1, 1'b0, N, -1);

        // Reset in the middle of a frame abandons it.
        run_frame(3, 1'b0, 30, -1);
        rstn = 1'b0;
        tick();
        check("midrst_tvalid", 32'(m_tvalid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tlast", 32'(m_tlast), 32'd0);
        check("midrst_s_tready", 32'(s_tready), 32'd0);
        rstn = 1'b1;
        tick();
        check("midrst_tready_back", 32'(s_tready), 32'd1);
        $display("reset mid-frame");
        run_frame(3, 1'b0, N, -1);

        // Random shifts with random sink back-pressure.
        repeat (3) begin
            r = int'($urandom_range(0, N - 1));
            run_frame(r, 1'b1, N, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
